time_set_ctrl: RTL

Upstream time-setting controller for the clock counter. Debounces three board push-buttons, runs a set-mode state machine that edits hours/minutes/seconds fields, and drives the counter's load inputs (`newHours`/`newMinutes`/`newSeconds` plus its load/reset strobe). The counter samples load only on its 1 Hz divided clock, so this block holds `load` long enough to guarantee capture.

---
 rtl/clock_pkg.sv | 40 ++++
 rtl/btn_debounce.sv | 37 +++
 rtl/time_set_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// Shared encodings, field limits and wrap helpers for the time-setting controller.
package clock_pkg;

  localparam int unsigned FIELD_W = 8;
  localparam int unsigned HOLD_W  = 27;

  localparam logic [FIELD_W-1:0] HOURS_MAX  = 8'd23;
  localparam logic [FIELD_W-1:0] MINSEC_MAX = 8'd59;

  localparam logic [1:0] EDIT_NONE = 2'd0;
  localparam logic [1:0] EDIT_H    = 2'd1;
  localparam logic [1:0] EDIT_M    = 2'd2;
  localparam logic [1:0] EDIT_S    = 2'd3;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_RUN   = 3'd1,
    ST_SET_H = 3'd2,
    ST_SET_M = 3'd3,
    ST_SET_S = 3'd4,
    ST_HOLD  = 3'd5
  } state_t;

  function automatic logic [FIELD_W-1:0] inc_wrap(input logic [FIELD_W-1:0] v,
                                                 input logic [FIELD_W-1:0] max);
    return (v == max) ? 8'd0 : v + 8'd1;
  endfunction

  function automatic logic [FIELD_W-1:0] dec_wrap(input logic [FIELD_W-1:0] v,
                                                 input logic [FIELD_W-1:0] max);
    return (v == 8'd0) ? max : v - 8'd1;
  endfunction

  // Captured live time may be garbage; anything past the field limit restarts at 0.
  function automatic logic [FIELD_W-1:0] clamp_zero(input logic [FIELD_W-1:0] v,
                                                   input logic [FIELD_W-1:0] max);
    return (v > max) ? 8'd0 : v;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stable-high counter, one pulse per press.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic pulse
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // Counter saturates at DEBOUNCE_CYCLES so a held button fires only once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      pulse <= 1'b0;
      if (!sync2) begin
        cnt <= '0;
      end else if (cnt != CNT_W'(DEBOUNCE_CYCLES)) begin
        cnt   <= cnt + CNT_W'(1);
        pulse <= (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
      end
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Set-mode controller: debounced buttons edit H/M/S and drive the counter's load strobe.
module time_set_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned LOAD_HOLD       = 100_000_001
) (
  input  logic               CLK100MHZ,
  input  logic               reset,
  input  logic               btn_mode,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic [FIELD_W-1:0] cur_hours,
  input  logic [FIELD_W-1:0] cur_minutes,
  input  logic [FIELD_W-1:0] cur_seconds,
  output logic [FIELD_W-1:0] newHours,
  output logic [FIELD_W-1:0] newMinutes,
  output logic [FIELD_W-1:0] newSeconds,
  output logic               load,
  output logic               setting,
  output logic [1:0]         edit_field
);

  logic               mode_p;
  logic               up_p;
  logic               down_p;
  logic               inc;
  logic               dec;
  logic               hold_done;
  state_t             state;
  logic [FIELD_W-1:0] hours;
  logic [FIELD_W-1:0] minutes;
  logic [FIELD_W-1:0] seconds;
  logic [HOLD_W-1:0]  hold_cnt;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clk(CLK100MHZ), .rst_n(reset), .raw(btn_mode), .pulse(mode_p)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk(CLK100MHZ), .rst_n(reset), .raw(btn_up), .pulse(up_p)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .clk(CLK100MHZ), .rst_n(reset), .raw(btn_down), .pulse(down_p)
  );

  // Opposing pulses cancel; mode priority is handled in the state machine.
  assign inc       = up_p && !down_p;
  assign dec       = down_p && !up_p;
  assign hold_done = (hold_cnt == HOLD_W'(LOAD_HOLD - 1));

  assign newHours   = hours;
  assign newMinutes = minutes;
  assign newSeconds = seconds;

  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      state      <= ST_INIT;
      hours      <= '0;
      minutes    <= '0;
      seconds    <= '0;
      load       <= 1'b1;
      setting    <= 1'b0;
      edit_field <= EDIT_NONE;
      hold_cnt   <= '0;
    end else begin
      case (state)
        // INIT and HOLD both keep load high long enough for a divided-clock capture.
        ST_INIT, ST_HOLD: begin
          load       <= 1'b1;
          setting    <= 1'b0;
          edit_field <= EDIT_NONE;
          if (hold_done) begin
            state    <= ST_RUN;
            load     <= 1'b0;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        ST_RUN: begin
          load       <= 1'b0;
          setting    <= 1'b0;
          edit_field <= EDIT_NONE;
          if (mode_p) begin
            hours      <= clamp_zero(cur_hours, HOURS_MAX);
            minutes    <= clamp_zero(cur_minutes, MINSEC_MAX);
            seconds    <= clamp_zero(cur_seconds, MINSEC_MAX);
            state      <= ST_SET_H;
            load       <= 1'b1;
            setting    <= 1'b1;
            edit_field <= EDIT_H;
          end
        end
        ST_SET_H: begin
          if (mode_p) begin
            state      <= ST_SET_M;
            edit_field <= EDIT_M;
          end else if (inc) begin
            hours <= inc_wrap(hours, HOURS_MAX);
          end else if (dec) begin
            hours <= dec_wrap(hours, HOURS_MAX);
          end
        end
        ST_SET_M: begin
          if (mode_p) begin
            state      <= ST_SET_S;
            edit_field <= EDIT_S;
          end else if (inc) begin
            minutes <= inc_wrap(minutes, MINSEC_MAX);
          end else if (dec) begin
            minutes <= dec_wrap(minutes, MINSEC_MAX);
          end
        end
        ST_SET_S: begin
          if (mode_p) begin
            state      <= ST_HOLD;
            setting    <= 1'b0;
            edit_field <= EDIT_NONE;
            hold_cnt   <= '0;
          end else if (inc) begin
            seconds <= inc_wrap(seconds, MINSEC_MAX);
          end else if (dec) begin
            seconds <= dec_wrap(seconds, MINSEC_MAX);
          end
        end
        default: begin
          state      <= ST_INIT;
          load       <= 1'b1;
          setting    <= 1'b0;
          edit_field <= EDIT_NONE;
          hold_cnt   <= '0;
        end
      endcase
    end
  end

endmodule
